// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared UART receiver constants and FSM state encoding
package uart_rx_pkg;

    // Default bit timing: 25 MHz clock, 115200 baud.
    localparam int CLKS_PER_BIT_DEF = 217;
    localparam int HALF_BIT_DEF     = CLKS_PER_BIT_DEF / 2;

    // Data bits per frame (8N1).
    localparam int FRAME_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - rx input synchronizer with optional 3-tap majority vote
//
// Optional feature macro: UART_RX_MAJORITY_EN
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   rx       in   raw serial line, asynchronous to clk
//   line     out  synchronized line level used for edge/idle decisions
//   bit_val  out  value to use when sampling a bit (voted when majority is enabled)
//   primed   out  synchronizer pipeline holds real line data (not reset values)
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic line,
    output logic bit_val,
    output logic primed
);

    logic s1;
    logic s2;

`ifdef UART_RX_MAJORITY_EN
    // Two extra history taps. line is the middle tap so that the vote at any
    // sample point covers the cycle before, at and after that point; the whole
    // receiver therefore runs one cycle later than without the vote.
    logic       h1;
    logic       h2;
    logic [2:0] fill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            h1   <= 1'b1;
            h2   <= 1'b1;
            fill <= '0;
        end else begin
            s1   <= rx;
            s2   <= s1;
            h1   <= s2;
            h2   <= h1;
            fill <= {fill[1:0], 1'b1};
        end
    end

    assign line    = h1;
    assign bit_val = (s2 & h1) | (s2 & h2) | (h1 & h2);
    assign primed  = fill[2];
`else
    logic [1:0] fill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            fill <= '0;
        end else begin
            s1   <= rx;
            s2   <= s1;
            fill <= {fill[0], 1'b1};
        end
    end

    assign line    = s2;
    assign bit_val = s2;
    assign primed  = fill[1];
`endif

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver for the MIX console link
//
// Optional feature macro: UART_RX_MAJORITY_EN (2-of-3 vote per bit sample)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   rx         in   serial line, idle high
//   out[7:0]   out  received byte, stable while valid=1
//   valid      out  byte available, held until ack
//   ack        in   one-cycle read strobe; clears valid, frame_err, overrun
//   frame_err  out  sticky: a frame ended with stop bit 0
//   overrun    out  sticky: a complete frame was dropped while valid=1
//   busy       out  receiver FSM not idle
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int HALF_BIT     = HALF_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] out,
    output logic       valid,
    input  logic       ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);
    localparam logic [3:0]  LAST_BIT  = 4'(FRAME_BITS - 1);

    logic line;
    logic bit_val;
    logic primed;

    state_t      state, state_n;
    logic [15:0] baud, baud_n;
    logic [3:0]  bitcnt, bitcnt_n;
    logic [7:0]  shift, shift_n;
    logic        armed;
    logic        deliver;
    logic        ferr_set;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (rx),
        .line    (line),
        .bit_val (bit_val),
        .primed  (primed)
    );

    // A start edge is only accepted once the line has been seen high after
    // reset, so a line that is already low when reset releases is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
        end else if (primed && line) begin
            armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            baud   <= '0;
            bitcnt <= '0;
            shift  <= '0;
        end else begin
            state  <= state_n;
            baud   <= baud_n;
            bitcnt <= bitcnt_n;
            shift  <= shift_n;
        end
    end

    always_comb begin
        state_n  = state;
        baud_n   = baud;
        bitcnt_n = bitcnt;
        shift_n  = shift;
        deliver  = 1'b0;
        ferr_set = 1'b0;
        unique case (state)
            ST_IDLE: begin
                baud_n = '0;
                if (armed && !line) begin
                    state_n = ST_START;
                end
            end
            ST_START: begin
                // Resetting baud at the start-bit centre keeps every later
                // wrap at the middle of a bit.
                if (baud == HALF_LAST) begin
                    baud_n   = '0;
                    bitcnt_n = '0;
                    state_n  = bit_val ? ST_IDLE : ST_DATA;
                end else begin
                    baud_n = baud + 16'd1;
                end
            end
            ST_DATA: begin
                if (baud == BAUD_LAST) begin
                    baud_n   = '0;
                    shift_n  = {bit_val, shift[7:1]};
                    bitcnt_n = bitcnt + 4'd1;
                    if (bitcnt == LAST_BIT) begin
                        state_n = ST_STOP;
                    end
                end else begin
                    baud_n = baud + 16'd1;
                end
            end
            ST_STOP: begin
                if (baud == BAUD_LAST) begin
                    baud_n = '0;
                    if (bit_val) begin
                        deliver = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_n  = ST_BREAK;
                    end
                end else begin
                    baud_n = baud + 16'd1;
                end
            end
            ST_BREAK: begin
                baud_n = '0;
                if (line) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Output holding register. A delivery coinciding with ack replaces the
    // byte; a delivery while an unread byte is held is dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (deliver && (!valid || ack)) begin
                out <= shift;
            end

            if (deliver) begin
                valid <= 1'b1;
            end else if (ack) begin
                valid <= 1'b0;
            end

            if (deliver && valid && !ack) begin
                overrun <= 1'b1;
            end else if (ack) begin
                overrun <= 1'b0;
            end

            if (ferr_set) begin
                frame_err <= 1'b1;
            end else if (ack) begin
                frame_err <= 1'b0;
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule
